// File: rtl/des_pkg.sv
// ----------------------------------------------------------------------------
// des_pkg
// Shared DES key-schedule definitions: the PC-1 and PC-2 selection tables,
// the per-round left-shift schedule, the subkey generator FSM state encoding
// and small rotate helpers for the 28-bit C/D halves.
//
// Table entries use FIPS 46 numbering (bit 1 is the most significant bit of
// the vector being selected from). A table entry t applied to an N-bit
// source therefore selects vector index N - t.
// ----------------------------------------------------------------------------
package des_pkg;

    localparam int KEY_W      = 64;
    localparam int CD_W       = 56;
    localparam int HALF_W     = 28;
    localparam int SUBKEY_W   = 48;
    localparam int NUM_ROUNDS = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } des_state_e;

    // PC-1: 64-bit key (with parity) -> 56-bit C||D. Parity bits 8,16,..,64
    // never appear in this table, which is how they are discarded.
    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: 56-bit C||D -> 48-bit round subkey.
    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotate amount for rounds 1..16 (index 0 is round 1). Sums to 28.
    localparam int SHIFT_SCHED [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // True when the schedule entry at idx (0-based round) rotates by two.
    function automatic logic shift_is_two(input logic [3:0] idx);
        return (SHIFT_SCHED[idx] == 2);
    endfunction

    // Rotate a 28-bit half left by one or two positions.
    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    // Rotate a 28-bit half right by one or two positions.
    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_subkey_gen_if.sv
// ----------------------------------------------------------------------------
// des_subkey_gen_if
// Bundles the key-load handshake and the subkey-stream handshake of the DES
// subkey generator.
//
//   i_key_valid     key-load request from the key source
//   o_key_ready     generator idle and able to accept a key
//   i_key[63:0]     DES key with parity bits, i_key[63] is FIPS bit 1
//   i_decrypt       0: emit K1..K16, 1: emit K16..K1 (sampled at load)
//   o_subkey_valid  o_subkey holds a valid subkey
//   i_subkey_ready  consumer accepts the current subkey
//   o_subkey[47:0]  registered round subkey, o_subkey[47] is PC-2 bit 1
//   o_round[3:0]    emission index 0..15 of the current subkey
//   o_busy          generator is emitting a sequence
//
// slave  : the subkey generator
// master : the key source / subkey consumer
// ----------------------------------------------------------------------------
interface des_subkey_gen_if;

    logic        i_key_valid;
    logic        o_key_ready;
    logic [63:0] i_key;
    logic        i_decrypt;
    logic        o_subkey_valid;
    logic        i_subkey_ready;
    logic [47:0] o_subkey;
    logic [3:0]  o_round;
    logic        o_busy;

    modport slave (
        input  i_key_valid,
        input  i_key,
        input  i_decrypt,
        input  i_subkey_ready,
        output o_key_ready,
        output o_subkey_valid,
        output o_subkey,
        output o_round,
        output o_busy
    );

    modport master (
        output i_key_valid,
        output i_key,
        output i_decrypt,
        output i_subkey_ready,
        input  o_key_ready,
        input  o_subkey_valid,
        input  o_subkey,
        input  o_round,
        input  o_busy
    );

endinterface

// File: rtl/des_subkey_gen_pc2.sv
// ----------------------------------------------------------------------------
// des_pc2
// Purely combinational DES Permuted Choice 2.
//
//   i_cd[55:0]      C||D halves, i_cd[55] is FIPS bit 1 of C
//   o_subkey[47:0]  selected round subkey, o_subkey[47] is PC-2 output bit 1
// ----------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] i_cd,
    output logic [47:0] o_subkey
);

    // Pure wiring: each output bit picks one C||D bit named by the table.
    for (genvar g = 0; g < SUBKEY_W; g++) begin : g_pc2
        assign o_subkey[SUBKEY_W - 1 - g] = i_cd[CD_W - PC2_TABLE[g]];
    end

endmodule

// File: rtl/des_subkey_gen.sv
// ----------------------------------------------------------------------------
// des_subkey_gen
// Generates the sixteen 48-bit DES round subkeys from a 64-bit key and
// streams them out over a valid/ready handshake, in encrypt order (K1..K16)
// or decrypt order (K16..K1).
//
//   i_clk    clock, all state changes on its rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      des_subkey_gen_if.slave (key load + subkey stream, see the
//            interface file for the individual signals)
//
// The C/D halves are rotated in place: left by the schedule for encrypt,
// right by the schedule read backwards for decrypt. The subkey register is
// loaded from PC-2 of the *next* C/D value, so a subkey appears the cycle
// after the event that produced it (key load or accepted handshake).
// ----------------------------------------------------------------------------
module des_subkey_gen
    import des_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    des_subkey_gen_if.slave   bus
);

    des_state_e   state_q, state_d;
    logic [27:0]  c_half_q, c_half_d;
    logic [27:0]  d_half_q, d_half_d;
    logic         decrypt_q, decrypt_d;
    logic [3:0]   round_q, round_d;
    logic [47:0]  subkey_q, subkey_d;

    logic [55:0]  pc1_cd;
    logic [47:0]  pc2_subkey;
    logic         load_subkey;
    logic [3:0]   next_round;
    logic [3:0]   dec_sched_idx;

    // PC-1 wiring from the raw key; parity bits are simply never selected.
    for (genvar g = 0; g < CD_W; g++) begin : g_pc1
        assign pc1_cd[CD_W - 1 - g] = bus.i_key[KEY_W - PC1_TABLE[g]];
    end

    // PC-2 sees the halves as they will be after this cycle's update.
    des_pc2 u_pc2 (
        .i_cd     ({c_half_d, d_half_d}),
        .o_subkey (pc2_subkey)
    );

    assign next_round    = round_q + 4'd1;
    // Decrypt emission j (1..15) undoes round 17-j, i.e. schedule index 16-j.
    assign dec_sched_idx = 4'd15 - round_q;

    // Next-state logic. A key load primes the halves for emission 0; each
    // accepted subkey below the last one advances the halves by one round.
    // The final handshake returns to IDLE and leaves the subkey register as
    // is, since it is only meaningful while valid is high.
    always_comb begin
        state_d     = state_q;
        c_half_d    = c_half_q;
        d_half_d    = d_half_q;
        decrypt_d   = decrypt_q;
        round_d     = round_q;
        load_subkey = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_key_valid) begin
                    state_d     = ST_EMIT;
                    decrypt_d   = bus.i_decrypt;
                    round_d     = 4'd0;
                    load_subkey = 1'b1;
                    if (bus.i_decrypt) begin
                        // K16 uses the halves exactly as PC-1 produced them,
                        // because the encrypt rotations total a full turn.
                        c_half_d = pc1_cd[55:28];
                        d_half_d = pc1_cd[27:0];
                    end else begin
                        c_half_d = rotl28(pc1_cd[55:28], shift_is_two(4'd0));
                        d_half_d = rotl28(pc1_cd[27:0],  shift_is_two(4'd0));
                    end
                end
            end
            ST_EMIT: begin
                if (bus.i_subkey_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = ST_IDLE;
                        round_d = 4'd0;
                    end else begin
                        round_d     = next_round;
                        load_subkey = 1'b1;
                        if (decrypt_q) begin
                            c_half_d = rotr28(c_half_q, shift_is_two(dec_sched_idx));
                            d_half_d = rotr28(d_half_q, shift_is_two(dec_sched_idx));
                        end else begin
                            c_half_d = rotl28(c_half_q, shift_is_two(next_round));
                            d_half_d = rotl28(d_half_q, shift_is_two(next_round));
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        subkey_d = load_subkey ? pc2_subkey : subkey_q;
    end

    // State and datapath registers; reset aborts any sequence in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            c_half_q  <= '0;
            d_half_q  <= '0;
            decrypt_q <= 1'b0;
            round_q   <= '0;
            subkey_q  <= '0;
        end else begin
            state_q   <= state_d;
            c_half_q  <= c_half_d;
            d_half_q  <= d_half_d;
            decrypt_q <= decrypt_d;
            round_q   <= round_d;
            subkey_q  <= subkey_d;
        end
    end

    assign bus.o_key_ready    = (state_q == ST_IDLE);
    assign bus.o_subkey_valid = (state_q == ST_EMIT);
    assign bus.o_busy         = (state_q == ST_EMIT);
    assign bus.o_subkey       = subkey_q;
    assign bus.o_round        = round_q;

endmodule

// File: doc/des_subkey_gen.md
DES_SUBKEY_GEN -- requirements
Module: des_subkey_gen

Interface
REQ-001 The module SHALL have no parameters; DES is fixed at 16 rounds, 64-bit key, 48-bit subkey.
REQ-002 i_clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_key_valid  input  1  key-load request.
REQ-005 o_key_ready  output  1  high only when IDLE; a key loads on the edge where i_key_valid and o_key_ready are both high.
REQ-006 i_key  input  64  DES key with parity bits; i_key[63] is FIPS 46 bit 1.
REQ-007 i_decrypt  input  1  0 = emit K1..K16, 1 = emit K16..K1; sampled only at key load.
REQ-008 o_subkey_valid  output  1  o_subkey holds a valid subkey.
REQ-009 i_subkey_ready  input  1  consumer accepts the subkey on an edge where it and o_subkey_valid are both high.
REQ-010 o_subkey  output  48  registered round subkey; o_subkey[47] is PC-2 output bit 1.
REQ-011 o_round  output  4  emission index 0..15 of the current subkey, in emission order.
REQ-012 o_busy  output  1  high in EMIT.

Function
REQ-013 The FSM SHALL have two states, IDLE and EMIT; IDLE goes to EMIT on key load, and EMIT goes to IDLE on the handshake with o_round==15.
REQ-014 At key load the block SHALL apply PC-1 to i_key (parity bits discarded), producing 28-bit halves C,D, and latch i_decrypt.
REQ-015 The encrypt shift schedule SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (round 1..16).
REQ-016 Encrypt: emission j (0..15) SHALL be PC-2(C,D) after C,D are each rotated left by shift[j+1]; the rotate for emission 0 is applied at load.
REQ-017 Decrypt: emission 0 SHALL be PC-2 of the unrotated PC-1 halves (K16); before emission j>=1, C,D SHALL each rotate right by shift[17-j], giving the right-shift sequence 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-018 o_subkey_valid SHALL assert the cycle after key load, with o_round=0; latency from load to first subkey is 1 cycle.
REQ-019 While o_subkey_valid is high and i_subkey_ready is low, o_subkey and o_round SHALL hold stable.
REQ-020 On each handshake with o_round<15, the next subkey SHALL be presented the following cycle, so throughput is 1 subkey per cycle with ready held high.
REQ-021 On the handshake with o_round==15, o_subkey_valid SHALL drop and o_key_ready SHALL rise the next cycle; o_round SHALL wrap to 0.
REQ-022 i_key_valid during EMIT SHALL be ignored (o_key_ready low), with no loss or corruption of the sequence in flight.
REQ-023 i_key and i_decrypt changes after load SHALL have no effect on the sequence in flight.
REQ-024 After 16 encrypt emissions the C,D rotation total SHALL be 28, returning the halves to their load values.

Reset
REQ-025 While i_rst_n is low: state=IDLE, o_key_ready=1, o_subkey_valid=0, o_busy=0, o_subkey=0, o_round=0, and C, D and the latched direction are cleared.
REQ-026 Reset asserted mid-EMIT SHALL abort the sequence immediately (asynchronously); no partial sequence resumes after release.
REQ-027 The first key load SHALL be possible on the first rising edge after i_rst_n deasserts.

Structure
REQ-028 The PC-1 table, PC-2 table, shift schedule and FSM state encoding SHALL live in a shared package des_pkg, for reuse by the round datapath.
REQ-029 PC-2 SHALL be a combinational sub-module des_pc2 (56-bit in, 48-bit out); its output feeds the o_subkey register.

Verification
REQ-030 Encrypt, key 0x133457799BBCDFF1, ready held high -> emission 0 = 0x1B02EFFC7072, emission 1 = 0x79AED9DBC9E5, emission 15 = 0xCB3D8B0E17F5, in 16 consecutive cycles.
REQ-031 Decrypt, same key -> emission 0 = 0xCB3D8B0E17F5, emission 15 = 0x1B02EFFC7072; the full sequence is the exact reverse of REQ-030.
REQ-032 Random i_subkey_ready stalls -> o_subkey and o_round stable during every stall; 16 handshakes in total, then o_key_ready=1.
REQ-033 i_key_valid pulsed with key 0xFFFFFFFFFFFFFFFF at emission 5 -> ignored; the remaining REQ-030 values are unchanged.
REQ-034 i_rst_n low at emission 7 -> o_subkey_valid=0 and o_subkey=0 immediately; after release a new load restarts at emission 0.
REQ-035 Two keys loaded back-to-back, i_decrypt toggled between them -> the second sequence starts 1 cycle after the second load, with correct direction.
